// File: rtl/clock_monitor.sv
// ============================================================================
// clock_monitor : measures high/low/period of an asynchronous clock in clk_pi
// cycles, flags out-of-range phases and stuck clocks, and reports lock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 3,
  parameter int MAX_HIGH    = 5,
  parameter int MIN_LOW     = 3,
  parameter int MAX_LOW     = 5,
  parameter int TIMEOUT     = 64,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             enable_pi,
  input  logic             mon_clk_pi,
  input  logic             clear_err_pi,
  output logic [CNT_W-1:0] high_cnt_po,
  output logic [CNT_W-1:0] low_cnt_po,
  output logic [CNT_W-1:0] period_cnt_po,
  output logic             meas_valid_po,
  output logic             locked_po,
  output logic             err_high_po,
  output logic             err_low_po,
  output logic             err_stuck_po
);

  localparam int LOCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEAS_HIGH = 2'd2;
  localparam logic [1:0] MEAS_LOW  = 2'd3;

  localparam logic [CNT_W-1:0]  c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_min_high = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]  c_max_high = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0]  c_min_low  = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0]  c_max_low  = CNT_W'(MAX_LOW);
  localparam logic [CNT_W-1:0]  c_timeout  = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] c_lock     = LOCK_W'(LOCK_CNT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                   err_high_q, err_high_d;
  logic                   err_low_q, err_low_d;
  logic                   err_stuck_q, err_stuck_d;

  logic             mon_sync, rise, fall, mon_edge;
  logic             run_high_ok, run_low_ok, cap_high_ok, timed_out;
  logic [CNT_W:0]   period_sum;
  logic [CNT_W-1:0] period_sat, run_inc;
  logic             set_high, set_low, set_stuck;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], mon_clk_pi};
    hist_d      = sync_q[SYNC_STAGES-1];
    mon_sync    = sync_q[SYNC_STAGES-1];
    rise        = mon_sync & ~hist_q;
    fall        = ~mon_sync & hist_q;
    mon_edge    = rise | fall;
    run_high_ok = (run_cnt_q >= c_min_high) && (run_cnt_q <= c_max_high);
    run_low_ok  = (run_cnt_q >= c_min_low) && (run_cnt_q <= c_max_low);
    cap_high_ok = (high_cnt_q >= c_min_high) && (high_cnt_q <= c_max_high);
    timed_out   = (run_cnt_q >= c_timeout);
    period_sum  = {1'b0, high_cnt_q} + {1'b0, run_cnt_q};
    period_sat  = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];
    run_inc     = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + c_one;
  end

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = mon_edge ? c_one : run_inc;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    set_high     = 1'b0;
    set_low      = 1'b0;
    set_stuck    = 1'b0;

    if (!enable_pi) begin
      state_d    = IDLE;
      run_cnt_d  = '0;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_cnt_d  = '0;
          lock_cnt_d = '0;
          state_d    = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_cnt_d = run_cnt_q;
            set_high   = !run_high_ok;
            state_d    = MEAS_LOW;
          end else if (timed_out) begin
            set_stuck = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            low_cnt_d    = run_cnt_q;
            period_cnt_d = period_sat;
            meas_valid_d = 1'b1;
            set_low      = !run_low_ok;
            state_d      = MEAS_HIGH;
            // A period counts toward lock only if both of its phases were in range.
            if (run_low_ok && cap_high_ok)
              lock_cnt_d = (lock_cnt_q == c_lock) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
            else
              lock_cnt_d = '0;
          end else if (timed_out) begin
            set_stuck = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (set_high || set_low || set_stuck) lock_cnt_d = '0;

    err_high_d  = set_high  | (err_high_q  & ~clear_err_pi);
    err_low_d   = set_low   | (err_low_q   & ~clear_err_pi);
    err_stuck_d = set_stuck | (err_stuck_q & ~clear_err_pi);
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync_q       <= '0;
      hist_q       <= 1'b0;
      state_q      <= IDLE;
      run_cnt_q    <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
      err_high_q   <= 1'b0;
      err_low_q    <= 1'b0;
      err_stuck_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      hist_q       <= hist_d;
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      lock_cnt_q   <= lock_cnt_d;
      err_high_q   <= err_high_d;
      err_low_q    <= err_low_d;
      err_stuck_q  <= err_stuck_d;
    end
  end

  assign high_cnt_po   = high_cnt_q;
  assign low_cnt_po    = low_cnt_q;
  assign period_cnt_po = period_cnt_q;
  assign meas_valid_po = meas_valid_q;
  assign locked_po     = (lock_cnt_q == c_lock);
  assign err_high_po   = err_high_q;
  assign err_low_po    = err_low_q;
  assign err_stuck_po  = err_stuck_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// ============================================================================
// tb_clock_monitor : directed stimulus with a queue-based measurement scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clock_monitor;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst, enable, mon, clear;
  logic [CNT_W-1:0] high_cnt, low_cnt, period_cnt;
  logic meas_valid, locked, err_high, err_low, err_stuck;

  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [CNT_W-1:0] p;
    logic lk;
    logic eh;
    logic el;
    logic es;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;
  logic prev_eh    = 1'b0;

  clock_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MIN_HIGH(3), .MAX_HIGH(5),
    .MIN_LOW(3), .MAX_LOW(5), .TIMEOUT(64), .LOCK_CNT(4)
  ) dut (
    .clk_pi        (clk),
    .rst_pi        (rst),
    .enable_pi     (enable),
    .mon_clk_pi    (mon),
    .clear_err_pi  (clear),
    .high_cnt_po   (high_cnt),
    .low_cnt_po    (low_cnt),
    .period_cnt_po (period_cnt),
    .meas_valid_po (meas_valid),
    .locked_po     (locked),
    .err_high_po   (err_high),
    .err_low_po    (err_low),
    .err_stuck_po  (err_stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int h, input int l, input logic lk,
                      input logic eh, input logic el, input logic es);
    exp_t e;
    e.h  = CNT_W'(h);
    e.l  = CNT_W'(l);
    e.p  = CNT_W'(h + l);
    e.lk = lk;
    e.eh = eh;
    e.el = el;
    e.es = es;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic lvl, input int n);
    mon = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int h, input int l, input logic lk,
                        input logic eh, input logic el, input logic es);
    push(h, l, lk, eh, el, es);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  // 4/4 period with a clear_err pulse in the middle of its low phase
  task automatic period_clear(input logic lk);
    push(4, 4, lk, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4);
    drive(1'b0, 2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drive(1'b0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_high"},   high_cnt,   '0);
    chk({tag, "_low"},    low_cnt,    '0);
    chk({tag, "_period"}, period_cnt, '0);
    chk({tag, "_valid"},  CNT_W'(meas_valid), '0);
    chk({tag, "_locked"}, CNT_W'(locked),     '0);
    chk({tag, "_err_hi"}, CNT_W'(err_high),   '0);
    chk({tag, "_err_lo"}, CNT_W'(err_low),    '0);
    chk({tag, "_err_st"}, CNT_W'(err_stuck),  '0);
  endtask

  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      chk("valid_one_cycle", CNT_W'(prev_valid), '0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_meas: got meas_valid with period %0d, expected no measurement (t=%0t)",
                 period_cnt, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("meas_high",   high_cnt,   mon_e.h);
        chk("meas_low",    low_cnt,    mon_e.l);
        chk("meas_period", period_cnt, mon_e.p);
        chk("meas_locked", CNT_W'(locked),    CNT_W'(mon_e.lk));
        chk("meas_err_hi", CNT_W'(err_high),  CNT_W'(mon_e.eh));
        chk("meas_err_lo", CNT_W'(err_low),   CNT_W'(mon_e.el));
        chk("meas_err_st", CNT_W'(err_stuck), CNT_W'(mon_e.es));
      end
    end
    if (err_high && !prev_eh) begin
      chk("err_high_drops_lock", CNT_W'(locked), '0);
      chk("err_high_capture",    high_cnt,       CNT_W'(7));
    end
    prev_valid <= meas_valid;
    prev_eh    <= err_high;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    mon    = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst    = 1'b0;
    enable = 1'b1;
    drive(1'b0, 6);

    // Nominal clk/8: lock on the 4th measurement
    for (int i = 0; i < 5; i++) period(4, 4, i >= 3, 1'b0, 1'b0, 1'b0);

    // One long high phase, relock, then clear
    period(7, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) period(4, 4, i == 3, 1'b1, 1'b0, 1'b0);
    period_clear(1'b1);
    chk("err_high_cleared", CNT_W'(err_high), '0);

    // Stuck-high monitored clock
    mon = 1'b1;
    repeat (60) @(negedge clk);
    chk("stuck_not_yet", CNT_W'(err_stuck), '0);
    repeat (10) @(negedge clk);
    chk("stuck_set", CNT_W'(err_stuck), CNT_W'(1));
    chk("stuck_unlock", CNT_W'(locked), '0);
    repeat (30) @(negedge clk);
    drive(1'b0, 4);
    chk("stuck_fall_ignored", high_cnt, CNT_W'(4));
    for (int i = 0; i < 5; i++) period(4, 4, i >= 3, 1'b0, 1'b0, 1'b1);
    period_clear(1'b1);
    chk("err_stuck_cleared", CNT_W'(err_stuck), '0);

    // Short low captured in the same cycle as clear_err: set wins
    push(4, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4);
    drive(1'b0, 2);
    push(4, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    mon = 1'b1;
    repeat (SYNC) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drive(1'b1, 1);
    drive(1'b0, 4);
    chk("err_low_set_wins", CNT_W'(err_low), CNT_W'(1));

    // Reset in the middle of a low phase
    drive(1'b1, 4);
    drive(1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4);
    for (int i = 0; i < 5; i++) period(4, 4, i >= 3, 1'b0, 1'b0, 1'b0);

    // Enable dropped for 10 cycles; restored during a high phase
    drive(1'b1, 4);
    drive(1'b0, 2);
    enable = 1'b0;
    drive(1'b0, 4);
    chk("dis_locked", CNT_W'(locked), '0);
    chk("dis_high_held",   high_cnt,   CNT_W'(4));
    chk("dis_low_held",    low_cnt,    CNT_W'(4));
    chk("dis_period_held", period_cnt, CNT_W'(8));
    drive(1'b1, 6);
    enable = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 4);
    for (int i = 0; i < 4; i++) period(4, 4, i == 3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4);
    drive(1'b0, 4);

    chk("scoreboard_drained", CNT_W'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
